// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the two-port DDR local-interface arbiter.
package ddr_arb_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = 4;
    localparam int DEF_MAX_RD = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    typedef logic port_t;

endpackage

// File: rtl/ddr_rd_tag_fifo.sv
// Read-tag FIFO: remembers which port issued each outstanding read, in issue order.
module ddr_rd_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    output logic             head_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_tag = mem_q[rd_ptr_q];

endmodule

// File: rtl/ddr_local_arbiter.sv
// Round-robin arbiter sharing the DDR controller local port between two requesters.
// state    | meaning
// ST_IDLE  | no command presented; pick a winner when a port is eligible
// ST_ISSUE | command held on local_* until local_ready accepts it
module ddr_local_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W,
    parameter int MAX_RD = DEF_MAX_RD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rq0_read,
    input  logic                  rq0_write,
    input  logic [ADDR_W-1:0]     rq0_addr,
    input  logic [DATA_W-1:0]     rq0_wdata,
    input  logic [BE_W-1:0]       rq0_be,
    output logic                  rq0_ack,
    output logic                  rq0_rdata_valid,
    input  logic                  rq1_read,
    input  logic                  rq1_write,
    input  logic [ADDR_W-1:0]     rq1_addr,
    input  logic [DATA_W-1:0]     rq1_wdata,
    input  logic [BE_W-1:0]       rq1_be,
    output logic                  rq1_ack,
    output logic                  rq1_rdata_valid,
    output logic [DATA_W-1:0]     rq_rdata,
    input  logic                  local_init_done,
    input  logic                  local_ready,
    input  logic [DATA_W-1:0]     local_rdata,
    input  logic                  local_rdata_valid,
    output logic                  local_read_req,
    output logic                  local_write_req,
    output logic                  local_burstbegin,
    output logic [ADDR_W-1:0]     local_address,
    output logic [DATA_W-1:0]     local_wdata,
    output logic [BE_W-1:0]       local_be,
    output logic                  local_size,
    output logic [$clog2(MAX_RD):0] rd_outstanding,
    output logic                  rd_err
);
    localparam int CNT_W = $clog2(MAX_RD) + 1;

    state_t            state_q, state_d;
    port_t             win_q, win_d, rr_q, rr_d, sel;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [1:0]        rdv_q, rdv_d, elig;
    logic              err_q, err_d;
    logic              accept, push, pop, rd_ok, load, sel_wr;
    logic              fifo_full, fifo_empty, head_tag;
    logic [CNT_W-1:0]  fifo_count;

    ddr_rd_tag_fifo #(.DEPTH(MAX_RD), .CNT_W(CNT_W)) u_tag_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_tag (win_q),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            rr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdv_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        accept = (state_q == ST_ISSUE) && local_ready;
        push   = accept && rd_q;
        // A read loaded while another read is being pushed must still find a free tag slot.
        rd_ok  = !fifo_full && !(push && (fifo_count == CNT_W'(MAX_RD - 1)));
        elig[0] = rq0_write || (rq0_read && rd_ok);
        elig[1] = rq1_write || (rq1_read && rd_ok);
        if (accept) begin
            elig[win_q] = 1'b0;
        end
        if (!local_init_done) begin
            elig = '0;
        end
        sel    = (elig == 2'b11) ? rr_q : elig[1];
        sel_wr = sel ? rq1_write : rq0_write;

        state_d = state_q;
        win_d   = win_q;
        rr_d    = rr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                load = |elig;
            end
            ST_ISSUE: begin
                if (accept) begin
                    rr_d = ~win_q;
                    if (|elig) begin
                        load = 1'b1;
                    end else begin
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d = ST_ISSUE;
            win_d   = sel;
            wr_d    = sel_wr;
            rd_d    = !sel_wr;
            addr_d  = sel ? rq1_addr  : rq0_addr;
            wdata_d = sel ? rq1_wdata : rq0_wdata;
            be_d    = sel ? rq1_be    : rq0_be;
        end
    end

    always_comb begin
        pop   = local_rdata_valid && !fifo_empty;
        rdv_d = '0;
        if (pop) begin
            rdv_d[head_tag] = 1'b1;
        end
        err_d   = err_q || (local_rdata_valid && fifo_empty);
        rdata_d = local_rdata_valid ? local_rdata : rdata_q;
    end

    always_comb begin
        rq0_ack          = accept && !win_q;
        rq1_ack          = accept && win_q;
        rq0_rdata_valid  = rdv_q[0];
        rq1_rdata_valid  = rdv_q[1];
        rq_rdata         = rdata_q;
        local_read_req   = rd_q;
        local_write_req  = wr_q;
        local_burstbegin = rd_q || wr_q;
        local_address    = addr_q;
        local_wdata      = wdata_q;
        local_be         = be_q;
        local_size       = 1'b1;
        rd_outstanding   = fifo_count;
        rd_err           = err_q;
    end

endmodule

// File: tb/tb_ddr_local_arbiter.sv
// Scoreboard bench for ddr_local_arbiter: requester models drive ports, a monitor checks acks and read returns.
module tb_ddr_local_arbiter;

    typedef struct {
        logic        wr;
        logic [24:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        port;
        logic        wr;
        logic [24:0] addr;
        logic [31:0] data;
    } ack_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rq_read, rq_write;
    logic [24:0] rq_addr [2];
    logic [31:0] rq_wdata [2];
    logic [3:0]  rq_be [2];
    logic        rq0_ack, rq1_ack, rq0_rdata_valid, rq1_rdata_valid;
    logic [31:0] rq_rdata;
    logic        local_init_done, local_ready, local_rdata_valid;
    logic [31:0] local_rdata;
    logic        local_read_req, local_write_req, local_burstbegin, local_size;
    logic [24:0] local_address;
    logic [31:0] local_wdata;
    logic [3:0]  local_be;
    logic [3:0]  rd_outstanding;
    logic        rd_err;

    req_t pend0[$];
    req_t pend1[$];
    ack_t exp_ack[$];
    rd_t  exp_rd[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ddr_local_arbiter dut (
        .clk               (clk),
        .reset             (rst),
        .rq0_read          (rq_read[0]),
        .rq0_write         (rq_write[0]),
        .rq0_addr          (rq_addr[0]),
        .rq0_wdata         (rq_wdata[0]),
        .rq0_be            (rq_be[0]),
        .rq0_ack           (rq0_ack),
        .rq0_rdata_valid   (rq0_rdata_valid),
        .rq1_read          (rq_read[1]),
        .rq1_write         (rq_write[1]),
        .rq1_addr          (rq_addr[1]),
        .rq1_wdata         (rq_wdata[1]),
        .rq1_be            (rq_be[1]),
        .rq1_ack           (rq1_ack),
        .rq1_rdata_valid   (rq1_rdata_valid),
        .rq_rdata          (rq_rdata),
        .local_init_done   (local_init_done),
        .local_ready       (local_ready),
        .local_rdata       (local_rdata),
        .local_rdata_valid (local_rdata_valid),
        .local_read_req    (local_read_req),
        .local_write_req   (local_write_req),
        .local_burstbegin  (local_burstbegin),
        .local_address     (local_address),
        .local_wdata       (local_wdata),
        .local_be          (local_be),
        .local_size        (local_size),
        .rd_outstanding    (rd_outstanding),
        .rd_err            (rd_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Each requester holds its request until acked, then drops it (or presents the next one).
    task automatic requester(input int p);
        logic a;
        logic busy;
        logic got;
        req_t r;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            a = (p == 0) ? rq0_ack : rq1_ack;
            @(posedge clk);
            #1;
            if (busy && a) begin
                busy        = 1'b0;
                rq_read[p]  = 1'b0;
                rq_write[p] = 1'b0;
            end
            if (!busy) begin
                got = 1'b0;
                if (p == 0 && pend0.size() > 0) begin
                    r = pend0.pop_front();
                    got = 1'b1;
                end else if (p == 1 && pend1.size() > 0) begin
                    r = pend1.pop_front();
                    got = 1'b1;
                end
                if (got) begin
                    busy        = 1'b1;
                    rq_write[p] = r.wr;
                    rq_read[p]  = !r.wr;
                    rq_addr[p]  = r.addr;
                    rq_wdata[p] = r.data;
                    rq_be[p]    = r.be;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        ack_t e;
        rd_t  d;
        if (rq0_ack || rq1_ack) begin
            if (rq0_ack && rq1_ack) begin
                fail_now("ack_both", "both ports acked in one cycle");
            end else if (exp_ack.size() == 0) begin
                fail_now("ack_unexpected", $sformatf("ack on port %0d with nothing expected", rq1_ack));
            end else begin
                e = exp_ack.pop_front();
                check("ack_port", 64'(rq1_ack), 64'(e.port));
                check("ack_cmd", 64'({local_read_req, local_write_req}), 64'({!e.wr, e.wr}));
                check("ack_addr", 64'(local_address), 64'(e.addr));
                if (e.wr) check("ack_wdata", 64'(local_wdata), 64'(e.data));
            end
        end
        if (rq0_rdata_valid || rq1_rdata_valid) begin
            if (rq0_rdata_valid && rq1_rdata_valid) begin
                fail_now("rdv_both", "both read strobes in one cycle");
            end else if (exp_rd.size() == 0) begin
                fail_now("rdv_unexpected", $sformatf("read strobe on port %0d with nothing expected", rq1_rdata_valid));
            end else begin
                d = exp_rd.pop_front();
                check("rdv_port", 64'(rq1_rdata_valid), 64'(d.port));
                check("rdv_data", 64'(rq_rdata), 64'(d.data));
            end
        end
    end

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #2;
            if (exp_ack.size() == 0 && exp_rd.size() == 0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s: timeout, %0d acks and %0d returns still expected", name, exp_ack.size(), exp_rd.size());
            exp_ack.delete();
            exp_rd.delete();
        end
    endtask

    task automatic ret_burst(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            local_rdata       = base + 32'(i);
            local_rdata_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        local_rdata_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({rq0_ack, rq1_ack, rq0_rdata_valid, rq1_rdata_valid,
                                  local_read_req, local_write_req, local_burstbegin, rd_err}), 64'd0);
        check({tag, "_data"}, {7'd0, local_address, local_wdata}, 64'd0);
        check({tag, "_rdata_be"}, 64'({rq_rdata, local_be}), 64'd0);
        check({tag, "_outstanding"}, 64'(rd_outstanding), 64'd0);
        check({tag, "_size"}, 64'(local_size), 64'd1);
    endtask

    task automatic wait_read_req(input logic [24:0] addr, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (local_read_req && local_address == addr) seen = 1'b1;
        end
        if (!seen) fail_now("wait_read_req", $sformatf("no read command for %0h", addr));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          bad;
        bit          seen;
        int          cnt;
        logic [59:0] snap;

        rst = 1'b1;
        rq_read = '0;
        rq_write = '0;
        for (int i = 0; i < 2; i++) begin
            rq_addr[i] = '0;
            rq_wdata[i] = '0;
            rq_be[i] = '0;
        end
        local_init_done = 1'b0;
        local_ready = 1'b1;
        local_rdata = '0;
        local_rdata_valid = 1'b0;
        fork
            requester(0);
            requester(1);
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("reset0");
        @(posedge clk);
        #1 rst = 1'b0;

        // No arbitration until calibration completes.
        @(negedge clk);
        pend0.push_back('{1'b1, 25'h0ABCDE, 32'h11223344, 4'hF});
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (local_write_req || rq0_ack) bad = 1'b1;
        end
        check("pre_init_idle", 64'(bad), 64'd0);
        exp_ack.push_back('{1'b0, 1'b1, 25'h0ABCDE, 32'h11223344});
        @(posedge clk);
        #1 local_init_done = 1'b1;
        @(negedge clk);
        check("init_not_yet", 64'(local_write_req), 64'd0);
        @(negedge clk);
        check("init_write_req", 64'({local_write_req, local_burstbegin}), 64'b11);
        check("init_addr_data", {7'd0, local_address, local_wdata}, {7'd0, 25'h0ABCDE, 32'h11223344});
        wait_drain("init");

        // Stalled read: command must hold while local_ready is low.
        @(posedge clk);
        #1 local_ready = 1'b0;
        @(negedge clk);
        pend1.push_back('{1'b0, 25'h0000100, 32'h0, 4'hF});
        wait_read_req(25'h0000100, seen);
        snap = {local_read_req, local_write_req, local_burstbegin, local_address, local_wdata};
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if ({local_read_req, local_write_req, local_burstbegin, local_address, local_wdata} !== snap) bad = 1'b1;
        end
        check("stall_stable", 64'(bad), 64'd0);
        exp_ack.push_back('{1'b1, 1'b0, 25'h0000100, 32'h0});
        @(posedge clk);
        #1 local_ready = 1'b1;
        wait_drain("stall_ack");
        @(negedge clk);
        check("stall_outstanding", 64'(rd_outstanding), 64'd1);
        exp_rd.push_back('{1'b1, 32'hDEADBEEF});
        ret_burst(1, 32'hDEADBEEF);
        wait_drain("stall_return");
        @(negedge clk);
        check("stall_outstanding_0", 64'(rd_outstanding), 64'd0);

        // Fairness: both ports busy, acks alternate starting from port 0.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pend0.push_back('{1'b1, 25'h1000 + 25'(i), 32'hA000 + 32'(i), 4'hF});
            pend1.push_back('{1'b1, 25'h2000 + 25'(i), 32'hB000 + 32'(i), 4'h3});
            exp_ack.push_back('{1'b0, 1'b1, 25'h1000 + 25'(i), 32'hA000 + 32'(i)});
            exp_ack.push_back('{1'b1, 1'b1, 25'h2000 + 25'(i), 32'hB000 + 32'(i)});
        end
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rq0_ack || rq1_ack) seen = 1'b1;
        end
        cnt = 0;
        repeat (7) begin
            @(negedge clk);
            if (rq0_ack || rq1_ack) cnt++;
        end
        check("fair_back_to_back", 64'(cnt), 64'd7);
        wait_drain("fair");

        // Tag FIFO full: ninth read waits, writes still flow.
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            pend1.push_back('{1'b0, 25'h200 + 25'(i), 32'h0, 4'hF});
            if (i < 8) exp_ack.push_back('{1'b1, 1'b0, 25'h200 + 25'(i), 32'h0});
        end
        wait_drain("full_fill");
        repeat (5) @(negedge clk);
        check("full_outstanding", 64'(rd_outstanding), 64'd8);
        check("full_no_read", 64'(local_read_req), 64'd0);
        pend0.push_back('{1'b1, 25'h300, 32'h55AA55AA, 4'hF});
        exp_ack.push_back('{1'b0, 1'b1, 25'h300, 32'h55AA55AA});
        wait_drain("full_write");
        exp_rd.push_back('{1'b1, 32'h000000A0});
        exp_ack.push_back('{1'b1, 1'b0, 25'h208, 32'h0});
        ret_burst(1, 32'h000000A0);
        wait_drain("full_ninth");
        @(negedge clk);
        check("full_refill", 64'(rd_outstanding), 64'd8);
        for (int i = 0; i < 8; i++) exp_rd.push_back('{1'b1, 32'hB0 + 32'(i)});
        ret_burst(8, 32'hB0);
        wait_drain("full_drain");
        @(negedge clk);
        check("full_empty", 64'(rd_outstanding), 64'd0);

        // Interleaved owners: returns must route p0,p1,p1,p0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0 || i == 3) pend0.push_back('{1'b0, 25'h400 + 25'(i), 32'h0, 4'hF});
            else pend1.push_back('{1'b0, 25'h400 + 25'(i), 32'h0, 4'hF});
            exp_ack.push_back('{(i == 1 || i == 2), 1'b0, 25'h400 + 25'(i), 32'h0});
            wait_drain("ilv_issue");
        end
        exp_rd.push_back('{1'b0, 32'h0C0});
        exp_rd.push_back('{1'b1, 32'h0C1});
        exp_rd.push_back('{1'b1, 32'h0C2});
        exp_rd.push_back('{1'b0, 32'h0C3});
        ret_burst(4, 32'h0C0);
        wait_drain("ilv_return");
        @(negedge clk);
        check("ilv_empty", 64'(rd_outstanding), 64'd0);
        check("err_before_spurious", 64'(rd_err), 64'd0);
        ret_burst(1, 32'h12345678);
        repeat (3) @(negedge clk);
        check("spurious_err", 64'(rd_err), 64'd1);

        // Reset while a command is stalled with three reads outstanding.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pend0.push_back('{1'b0, 25'h500 + 25'(i), 32'h0, 4'hF});
            exp_ack.push_back('{1'b0, 1'b0, 25'h500 + 25'(i), 32'h0});
        end
        wait_drain("rst_fill");
        @(negedge clk);
        check("rst_pre_outstanding", 64'(rd_outstanding), 64'd3);
        @(posedge clk);
        #1 local_ready = 1'b0;
        @(negedge clk);
        pend1.push_back('{1'b0, 25'h510, 32'h0, 4'hF});
        wait_read_req(25'h510, seen);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        exp_ack.push_back('{1'b1, 1'b0, 25'h510, 32'h0});
        local_ready = 1'b1;
        wait_drain("rst_reissue");
        exp_rd.push_back('{1'b1, 32'hCAFEF00D});
        ret_burst(1, 32'hCAFEF00D);
        wait_drain("rst_return");
        @(negedge clk);
        check("rst_post_outstanding", 64'(rd_outstanding), 64'd0);
        check("rst_post_err", 64'(rd_err), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr_local_arbiter.md
Name: ddr_local_arbiter

Overview:
- Shares the single DDR SDRAM controller local port (25-bit word address, 32-bit data, size-1 bursts) between two requesters: port 0 (event-builder writer) and port 1 (readout reader). Either port may issue reads or writes.
- Sits between user logic and the controller/PHY wrapper, in the phy_clk domain.
- Round-robin arbitration, registered command issue, in-order routing of read data back to its originator through a read-tag FIFO.

Parameters:
- ADDR_W, 25, local word-address width
- DATA_W, 32, local data width
- BE_W, 4, byte-enable width (DATA_W/8)
- MAX_RD, 8, max outstanding reads; read-tag FIFO depth, power of two

Ports:
- clk  in  1  phy_clk from the controller; single clock
- reset  in  1  asynchronous, active-high
- rq0_read, rq1_read  in  1  read request, held until ack
- rq0_write, rq1_write  in  1  write request, held until ack
- rq0_addr, rq1_addr  in  ADDR_W  word address
- rq0_wdata, rq1_wdata  in  DATA_W  write data
- rq0_be, rq1_be  in  BE_W  byte enables
- rq0_ack, rq1_ack  out  1  one-cycle pulse: request accepted by controller
- rq0_rdata_valid, rq1_rdata_valid  out  1  read data strobe for that port
- rq_rdata  out  DATA_W  read data, shared by both ports
- local_init_done  in  1  controller calibration complete
- local_ready  in  1  controller accepts the presented command
- local_rdata  in  DATA_W  controller read data
- local_rdata_valid  in  1  controller read data strobe
- local_read_req, local_write_req, local_burstbegin  out  1  command to controller
- local_address  out  ADDR_W  command address
- local_wdata  out  DATA_W  command write data
- local_be  out  BE_W  command byte enables
- local_size  out  1  constant 1
- rd_outstanding  out  log2(MAX_RD)+1  reads issued but not yet returned
- rd_err  out  1  sticky: read data with no matching tag

Behaviour:
- Reset: all outputs 0 except local_size=1. Tag FIFO flushed, rr pointer=0, FSM in IDLE. A reset mid-transaction discards the in-flight command and tags.
- No arbitration while local_init_done=0.
- Eligibility per port:
  - write: rqN_write=1.
  - read: rqN_read=1 and tag FIFO not full.
  - Both asserted on one port: write is presented, read stays pending.
- FSM states IDLE and ISSUE.
- IDLE: if any port is eligible, select the winner (rr pointer favours port rr when both are eligible). Register the command onto local_* with exactly one of read/write req set and local_burstbegin=1. Go to ISSUE.
- ISSUE: hold all local_* stable while local_ready=0. On the cycle local_ready=1:
  - pulse rqN_ack for the winner (same cycle);
  - for a read, push tag=N;
  - set rr to the other port;
  - if an eligible request exists (requesters must drop an acked request next cycle, so the winner's still-high line is masked this cycle), load it in the same cycle and stay in ISSUE (back-to-back, one command per clock at best); else clear req/burstbegin and return to IDLE.
- Read return, independent of the FSM:
  - on local_rdata_valid, pop the head tag;
  - register rq_rdata=local_rdata and pulse rqT_rdata_valid one cycle later (latency 1).
  - rdata_valid with an empty FIFO: no strobe, set rd_err (cleared only by reset).
- Simultaneous push and pop: both take effect, occupancy unchanged. A full FIFO with a simultaneous pop does not make reads eligible that cycle (eligibility uses the registered full flag).
- rd_outstanding = FIFO occupancy, updated the cycle after push/pop.
- Ordering: the controller returns reads in issue order; routing relies on this.

Decomposition:
- Package ddr_arb_pkg: ADDR_W/DATA_W/BE_W defaults, FSM state encoding, port-index type.
- Sub-module ddr_rd_tag_fifo: synchronous 1-bit-wide FIFO of depth MAX_RD with full/empty/count, async active-high reset.

Test Plan:
- Before init_done: rq0_write=1, local_init_done=0 for 20 cycles -> local_write_req stays 0, no ack. Then init_done=1 -> local_write_req=1 with addr/data of rq0 on the second cycle.
- Stall: rq1_read addr 0x0000100, local_ready=0 for 5 cycles -> local_* stable throughout. local_ready=1 -> rq1_ack pulse, rd_outstanding becomes 1. local_rdata_valid with 0xDEADBEEF -> rq1_rdata_valid pulse next cycle, rq_rdata=0xDEADBEEF.
- Fairness: both ports request continuously, local_ready=1 -> acks alternate 0,1,0,1..., one command per clock.
- Tag full: port 1 issues 8 reads, no returns -> 9th read not issued and rd_outstanding=8; port 0 write still issued. One return -> 9th read issued.
- Interleaved returns: reads issued in order p0,p1,p1,p0 -> valids route to 0,1,1,0. A spurious local_rdata_valid with FIFO empty -> rd_err=1, no port strobe.
- Reset mid-issue: assert reset during ISSUE with 3 reads outstanding -> all outputs 0, rd_outstanding=0, rd_err=0. The next read after reset routes correctly.
